// File: rtl/ps2_scancode_rx_if.sv
// Signal bundle for the PS/2 receiver. It carries the raw keyboard pins in
// and the decoded key-event word plus error strobe out.
interface ps2_scancode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (output ps2_clk, ps2_data, input  ps2_key, frame_err);
  modport slave  (input  ps2_clk, ps2_data, output ps2_key, frame_err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with Set-2 prefix decoding. Each key event
// is published as a toggle-qualified 11-bit word for the keyboard matrix stage.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic             clk,
  input  logic             reset_n,
  ps2_scancode_rx_if.slave ps2
);

  localparam int              FW        = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [14:0]     TO_LAST   = 15'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_STOP} state_t;

  logic [1:0]    r_clk_sync, r_data_sync;
  logic [FW-1:0] r_clk_cnt, r_data_cnt;
  logic          r_clk_filt, r_data_filt, r_clk_filt_d;
  logic          w_fall;

  state_t        r_state, w_state;
  logic [2:0]    r_bit_cnt, w_bit_cnt;
  logic [7:0]    r_shift, w_shift;
  logic          r_parity, w_parity;
  logic [14:0]   r_idle_cnt, w_idle_cnt;
  logic          r_byte_valid, w_byte_valid;
  logic          r_frame_err, w_frame_err;

  logic          r_ext_pend, r_brk_pend;
  logic [2:0]    r_skip_cnt;
  logic [10:0]   r_key;
  logic          w_is_resp;

  // Lines idle high, so the synchronisers and filters come out of reset at 1.
  // Otherwise the first real sample would look like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync   <= 2'b11;
      r_data_sync  <= 2'b11;
      r_clk_cnt    <= '0;
      r_data_cnt   <= '0;
      r_clk_filt   <= 1'b1;
      r_data_filt  <= 1'b1;
      r_clk_filt_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here let every flop sample the pre-edge
      // value, which is what makes the two-flop chain an actual synchroniser.
      r_clk_sync   <= {r_clk_sync[0], ps2.ps2_clk};
      r_data_sync  <= {r_data_sync[0], ps2.ps2_data};
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FILT_LAST) begin
        r_clk_filt <= r_clk_sync[1];
        r_clk_cnt  <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
      if (r_data_sync[1] == r_data_filt) begin
        r_data_cnt <= '0;
      end else if (r_data_cnt == FILT_LAST) begin
        r_data_filt <= r_data_sync[1];
        r_data_cnt  <= '0;
      end else begin
        r_data_cnt <= r_data_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_clk_filt_d & ~r_clk_filt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_idle_cnt   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_bit_cnt    <= w_bit_cnt;
      r_shift      <= w_shift;
      r_parity     <= w_parity;
      r_idle_cnt   <= w_idle_cnt;
      r_byte_valid <= w_byte_valid;
      r_frame_err  <= w_frame_err;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    w_state      = r_state;
    w_bit_cnt    = r_bit_cnt;
    w_shift      = r_shift;
    w_parity     = r_parity;
    w_idle_cnt   = (r_state == S_IDLE) ? '0 : r_idle_cnt + 15'd1;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    // A timeout wins over an edge arriving in the same cycle.
    if (r_state != S_IDLE && r_idle_cnt == TO_LAST) begin
      w_state     = S_IDLE;
      w_idle_cnt  = '0;
      w_frame_err = 1'b1;
    end else if (w_fall) begin
      w_idle_cnt = '0;
      case (r_state)
        S_IDLE: begin
          if (r_data_filt) begin
            w_frame_err = 1'b1;
          end else begin
            w_state   = S_SHIFT;
            w_bit_cnt = '0;
          end
        end
        S_SHIFT: begin
          w_shift   = {r_data_filt, r_shift[7:1]};
          w_bit_cnt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state = S_PARITY;
        end
        S_PARITY: begin
          w_parity = r_data_filt;
          w_state  = S_STOP;
        end
        S_STOP: begin
          if (r_data_filt && (^{r_shift, r_parity})) w_byte_valid = 1'b1;
          else                                      w_frame_err  = 1'b1;
          w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // r_shift holds the completed byte during the byte_valid cycle. No new frame
  // can start shifting until many cycles later.
  assign w_is_resp = r_shift inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_skip_cnt <= '0;
      r_key      <= '0;
    end else if (r_frame_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_skip_cnt <= '0;
    end else if (r_byte_valid) begin
      if (r_skip_cnt != 3'd0) begin
        r_skip_cnt <= r_skip_cnt - 3'd1;
      end else if (r_shift == 8'hE0) begin
        r_ext_pend <= 1'b1;
      end else if (r_shift == 8'hF0) begin
        r_brk_pend <= 1'b1;
      end else if (r_shift == 8'hE1) begin
        r_skip_cnt <= 3'd7;
      end else if (r_ext_pend || r_brk_pend || !w_is_resp) begin
        r_key      <= {~r_key[10], ~r_brk_pend, r_ext_pend, r_shift};
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  assign ps2.ps2_key   = r_key;
  assign ps2.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx. It bit-bangs PS/2 frames and counts key
// toggles and error pulses on the opposite clock edge.
module tb_ps2_scancode_rx;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 24000;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  ps2_scancode_rx_if ifc ();

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2     (ifc.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   n_tog = 0, n_err = 0, n_wide = 0, chg_cyc = 0, stop_cyc = 0;
  logic prev_t = 1'b0, prev_err = 1'b0;
  logic exp_t = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ifc.ps2_key[10] !== prev_t) begin
        n_tog++;
        chg_cyc = cyc;
      end
      if (ifc.frame_err === 1'b1) begin
        n_err++;
        if (prev_err === 1'b1) n_wide++;
      end
      prev_t   = ifc.ps2_key[10];
      prev_err = ifc.frame_err;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device behaviour: data changes while the clock is high, and the host samples
  // on the falling clock edge.
  task automatic send_frame(input logic [7:0] b, input bit good_par, input int half,
                            input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (good_par ? ~^b : ^b), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ifc.ps2_data = bits[i];
      if (glitch && i == 5) begin
        wait_cyc(half / 2);
        ifc.ps2_clk = 1'b0;
        wait_cyc(3);
        ifc.ps2_clk = 1'b1;
        wait_cyc(half - half / 2 - 3);
      end else begin
        wait_cyc(half);
      end
      ifc.ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(half);
      ifc.ps2_clk = 1'b1;
    end
    ifc.ps2_data = 1'b1;
    wait_cyc(4 * half);
  endtask

  task automatic test_reset();
    logic [10:0] bits;
    int e0;
    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    #1 reset_n = 1'b0;
    wait_cyc(5);
    n_cmp++;
    if (ifc.ps2_key !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_key: got %h want 000", ifc.ps2_key);
    end
    n_cmp++;
    if (ifc.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b want 0", ifc.frame_err);
    end
    reset_n = 1'b1;
    wait_cyc(20);
    e0 = n_err;
    // Send a partial frame, then reset while the frame is still in progress.
    bits = {1'b1, 1'b0, 8'h5A, 1'b0};
    for (int i = 0; i < 3; i++) begin
      ifc.ps2_data = bits[i];
      wait_cyc(40);
      ifc.ps2_clk = 1'b0;
      wait_cyc(40);
      ifc.ps2_clk = 1'b1;
    end
    reset_n = 1'b0;
    wait_cyc(5);
    ifc.ps2_data = 1'b1;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(10000);
    n_cmp++;
    if (ifc.ps2_key !== 11'h000) begin
      n_bad++;
      $display("FAIL idle_key: got %h want 000", ifc.ps2_key);
    end
    n_cmp++;
    if (n_err - e0 !== 0 || n_tog !== 0) begin
      n_bad++;
      $display("FAIL idle_activity: err %0d tog %0d want 0 0", n_err - e0, n_tog);
    end
  endtask

  task automatic test_make();
    int t0, e0;
    t0 = n_tog;
    e0 = n_err;
    exp_t = ~exp_t;
    send_frame(8'h1C, 1'b1, 200, 1'b0);
    n_cmp++;
    if (ifc.ps2_key !== {exp_t, 1'b1, 1'b0, 8'h1C}) begin
      n_bad++;
      $display("FAIL make_key: got %h want %h", ifc.ps2_key, {exp_t, 10'h21C});
    end
    n_cmp++;
    if (n_tog - t0 !== 1 || n_err - e0 !== 0) begin
      n_bad++;
      $display("FAIL make_count: tog %0d err %0d want 1 0", n_tog - t0, n_err - e0);
    end
    n_cmp++;
    if (chg_cyc - stop_cyc > FILTER_LEN + 4 || chg_cyc - stop_cyc < 1) begin
      n_bad++;
      $display("FAIL make_latency: got %0d want 1..%0d", chg_cyc - stop_cyc, FILTER_LEN + 4);
    end
  endtask

  task automatic test_ext_break();
    int t0;
    t0 = n_tog;
    send_frame(8'hE0, 1'b1, 40, 1'b0);
    send_frame(8'hF0, 1'b1, 40, 1'b0);
    n_cmp++;
    if (n_tog - t0 !== 0) begin
      n_bad++;
      $display("FAIL ext_prefix_tog: got %0d want 0", n_tog - t0);
    end
    send_frame(8'h75, 1'b1, 40, 1'b0);
    exp_t = ~exp_t;
    n_cmp++;
    if (n_tog - t0 !== 1) begin
      n_bad++;
      $display("FAIL ext_brk_tog: got %0d want 1", n_tog - t0);
    end
    n_cmp++;
    if (ifc.ps2_key !== {exp_t, 10'h175}) begin
      n_bad++;
      $display("FAIL ext_brk_key: got %h want %h", ifc.ps2_key, {exp_t, 10'h175});
    end
  endtask

  task automatic test_parity_error();
    int t0, e0;
    t0 = n_tog;
    e0 = n_err;
    send_frame(8'h1C, 1'b0, 40, 1'b0);
    n_cmp++;
    if (n_err - e0 !== 1 || n_tog - t0 !== 0) begin
      n_bad++;
      $display("FAIL parity_err: err %0d tog %0d want 1 0", n_err - e0, n_tog - t0);
    end
    send_frame(8'h1C, 1'b1, 40, 1'b0);
    exp_t = ~exp_t;
    n_cmp++;
    if (ifc.ps2_key !== {exp_t, 10'h21C} || n_err - e0 !== 1) begin
      n_bad++;
      $display("FAIL parity_recover: key %h err %0d want %h 1", ifc.ps2_key, n_err - e0,
               {exp_t, 10'h21C});
    end
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    int e0, t0;
    e0 = n_err;
    t0 = n_tog;
    bits = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 5; i++) begin
      ifc.ps2_data = bits[i];
      wait_cyc(40);
      ifc.ps2_clk = 1'b0;
      wait_cyc(40);
      ifc.ps2_clk = 1'b1;
    end
    ifc.ps2_data = 1'b1;
    wait_cyc(TIMEOUT + 200);
    n_cmp++;
    if (n_err - e0 !== 1 || n_tog - t0 !== 0) begin
      n_bad++;
      $display("FAIL timeout_err: err %0d tog %0d want 1 0", n_err - e0, n_tog - t0);
    end
    send_frame(8'h29, 1'b1, 40, 1'b0);
    exp_t = ~exp_t;
    n_cmp++;
    if (ifc.ps2_key !== {exp_t, 10'h229}) begin
      n_bad++;
      $display("FAIL timeout_recover: got %h want %h", ifc.ps2_key, {exp_t, 10'h229});
    end
  endtask

  task automatic test_pause_ignore();
    logic [7:0] seq [9];
    int t0, e0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA};
    t0 = n_tog;
    e0 = n_err;
    for (int i = 0; i < 9; i++) send_frame(seq[i], 1'b1, 40, 1'b0);
    n_cmp++;
    if (n_tog - t0 !== 0) begin
      n_bad++;
      $display("FAIL pause_tog: got %0d want 0", n_tog - t0);
    end
    send_frame(8'h16, 1'b1, 40, 1'b1);
    exp_t = ~exp_t;
    n_cmp++;
    if (n_tog - t0 !== 1 || ifc.ps2_key !== {exp_t, 10'h216}) begin
      n_bad++;
      $display("FAIL pause_event: tog %0d key %h want 1 %h", n_tog - t0, ifc.ps2_key,
               {exp_t, 10'h216});
    end
    n_cmp++;
    if (n_err - e0 !== 0 || n_wide !== 0) begin
      n_bad++;
      $display("FAIL pause_err: err %0d wide %0d want 0 0", n_err - e0, n_wide);
    end
  endtask

  initial begin
    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    test_reset();
    test_make();
    test_ext_break();
    test_parity_error();
    test_timeout();
    test_pause_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
